// File: rtl/gpio_pads_shift_rx.sv
// Pad-side receiver for the GPIO daisy-chain configuration protocol: synchronises the
// controller's serial interface, shifts a NPADS*16-bit chain and loads per-pad config words.
module gpio_pads_shift_rx #(
  parameter int unsigned NPADS   = 4,
  parameter logic [15:0] CFG_RST = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_rstn,
  input  logic                  shift_clock,
  input  logic                  shift_load,
  input  logic                  shift_data,
  output logic                  shift_data_ret,
  output logic [NPADS*16-1:0]   pad_cfg,
  output logic                  cfg_update
);

  localparam int unsigned W = NPADS * 16;

  logic [1:0]   rstn_sync_q;
  logic [1:0]   data_sync_q;
  logic [2:0]   clk_sync_q;
  logic [2:0]   load_sync_q;
  logic [W-1:0] chain_q, chain_d;
  logic [W-1:0] pad_cfg_q, pad_cfg_d;
  logic         cfg_update_q, cfg_update_d;
  logic         ret_q;

  logic rstn_s2;
  logic clk_rise;
  logic load_fire;

  // Index 0 is the first synchroniser stage, 1 the second, 2 the edge-detect delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstn_sync_q <= '0;
      data_sync_q <= '0;
      clk_sync_q  <= '0;
      load_sync_q <= '0;
    end else begin
      rstn_sync_q <= {rstn_sync_q[0], shift_rstn};
      data_sync_q <= {data_sync_q[0], shift_data};
      clk_sync_q  <= {clk_sync_q[1:0], shift_clock};
      load_sync_q <= {load_sync_q[1:0], shift_load};
    end
  end

  assign rstn_s2   = rstn_sync_q[1];
  assign clk_rise  = clk_sync_q[1] & ~clk_sync_q[2];
  assign load_fire = load_sync_q[1] & ~load_sync_q[2] & rstn_s2;

  // A load in the same cycle as a shift captures the pre-shift chain.
  always_comb begin
    chain_d      = chain_q;
    pad_cfg_d    = pad_cfg_q;
    cfg_update_d = 1'b0;
    if (!rstn_s2) begin
      chain_d = '0;
    end else if (clk_rise) begin
      chain_d = {chain_q[W-2:0], data_sync_q[1]};
    end
    if (load_fire) begin
      pad_cfg_d    = chain_q;
      cfg_update_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q      <= '0;
      pad_cfg_q    <= {NPADS{CFG_RST}};
      cfg_update_q <= 1'b0;
      ret_q        <= 1'b0;
    end else begin
      chain_q      <= chain_d;
      pad_cfg_q    <= pad_cfg_d;
      cfg_update_q <= cfg_update_d;
      ret_q        <= chain_q[W-1];
    end
  end

  assign shift_data_ret = ret_q;
  assign pad_cfg        = pad_cfg_q;
  assign cfg_update     = cfg_update_q;

endmodule

// File: tb/tb_gpio_pads_shift_rx.sv
// Directed bench for gpio_pads_shift_rx: a sample-delay/queue model checked every cycle,
// plus literal expectations for each scenario.
module tb_gpio_pads_shift_rx;

  localparam int unsigned NPADS   = 4;
  localparam int unsigned W       = NPADS * 16;
  localparam logic [15:0] CFG_RST = 16'h0201;

  logic         clk         = 1'b0;
  logic         rst_n       = 1'b0;
  logic         shift_rstn  = 1'b1;
  logic         shift_clock = 1'b0;
  logic         shift_load  = 1'b0;
  logic         shift_data  = 1'b0;
  logic         shift_data_ret;
  logic [W-1:0] pad_cfg;
  logic         cfg_update;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  gpio_pads_shift_rx #(
    .NPADS   (NPADS),
    .CFG_RST (CFG_RST)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .shift_rstn     (shift_rstn),
    .shift_clock    (shift_clock),
    .shift_load     (shift_load),
    .shift_data     (shift_data),
    .shift_data_ret (shift_data_ret),
    .pad_cfg        (pad_cfg),
    .cfg_update     (cfg_update)
  );

  // Model: inputs as seen at the last three clock edges, and the chain as a queue of
  // received bits (index 0 = newest, which sits at chain bit 0).
  bit           q[$];
  logic [3:1]   hr = '0, hc = '0, hl = '0, hd = '0;
  logic [W-1:0] exp_cfg = {NPADS{CFG_RST}};
  logic         exp_upd = 1'b0;
  logic         exp_ret = 1'b0;
  logic [W-1:0] pre_chain;

  function automatic logic [W-1:0] chain_now();
    logic [W-1:0] v;
    v = '0;
    for (int j = 0; j < q.size(); j++) v[j] = q[j];
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        hr = '0; hc = '0; hl = '0; hd = '0;
        exp_cfg = {NPADS{CFG_RST}};
        exp_upd = 1'b0;
        exp_ret = 1'b0;
      end else begin
        pre_chain = chain_now();
        exp_ret   = pre_chain[W-1];
        exp_upd   = hl[2] & ~hl[3] & hr[2];
        if (exp_upd) exp_cfg = pre_chain;
        if (!hr[2]) q.delete();
        else if (hc[2] & ~hc[3]) begin
          q.push_front(hd[2]);
          if (q.size() > W) void'(q.pop_back());
        end
        hr = {hr[2:1], shift_rstn};
        hc = {hc[2:1], shift_clock};
        hl = {hl[2:1], shift_load};
        hd = {hd[2:1], shift_data};
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      check("pad_cfg", pad_cfg, exp_cfg);
      check("cfg_update", W'(cfg_update), W'(exp_upd));
      check("shift_data_ret", W'(shift_data_ret), W'(exp_ret));
      if (cfg_update) pulses++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(input logic b);
    shift_data = b;
    tick(2);
    shift_clock = 1'b1;
    tick(4);
    shift_clock = 1'b0;
    tick(2);
  endtask

  task automatic shift_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) shift_bit(w[i]);
  endtask

  task automatic zeros(input int n);
    repeat (n) shift_bit(1'b0);
  endtask

  task automatic load();
    shift_load = 1'b1;
    tick(3);
    shift_load = 1'b0;
    tick(5);
  endtask

  task automatic chain_clear();
    shift_rstn = 1'b0;
    tick(4);
    shift_rstn = 1'b1;
    tick(3);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int p0;
    logic [15:0] w;
    tick(3);
    rst_n = 1'b1;
    tick(100);
    check("idle pad_cfg", pad_cfg, {NPADS{CFG_RST}});
    check("idle pulses", W'(pulses), W'(0));

    chain_clear();
    p0 = pulses;
    shift_word(16'hA5C3);
    load();
    check("pad0 A5C3", pad_cfg, 64'h0000_0000_0000_A5C3);
    check("A5C3 pulses", W'(pulses - p0), W'(1));

    for (int k = 0; k < 4; k++) begin
      chain_clear();
      shift_word(16'h1234);
      zeros(16 * k);
      load();
      check($sformatf("sweep pad%0d", k), pad_cfg, W'(16'h1234) << (16 * k));
    end

    chain_clear();
    shift_word(16'hFFFF);
    zeros(47);
    shift_data = 1'b0;
    tick(2);
    shift_clock = 1'b1;
    tick(3);
    check("ret before 4 clk", W'(shift_data_ret), W'(0));
    tick(1);
    check("ret at 4 clk", W'(shift_data_ret), W'(1));
    shift_clock = 1'b0;
    tick(2);
    load();
    check("pad3 FFFF", pad_cfg, 64'hFFFF_0000_0000_0000);

    shift_data = 1'b1;
    tick(2);
    shift_clock = 1'b1;
    shift_load  = 1'b1;
    tick(3);
    shift_load = 1'b0;
    tick(1);
    shift_clock = 1'b0;
    tick(4);
    check("simul load pre-shift", pad_cfg, 64'hFFFF_0000_0000_0000);
    load();
    check("simul extra bit", pad_cfg, 64'hFFFE_0000_0000_0001);

    chain_clear();
    w = 16'hA5C3;
    for (int i = 15; i >= 8; i--) shift_bit(w[i]);
    #2 rst_n = 1'b0;
    #1;
    check("rst pad_cfg", pad_cfg, {NPADS{CFG_RST}});
    check("rst cfg_update", W'(cfg_update), W'(0));
    check("rst ret", W'(shift_data_ret), W'(0));
    tick(3);
    rst_n = 1'b1;
    tick(3);
    load();
    check("post-rst load", pad_cfg, '0);

    chain_clear();
    shift_word(16'hA5C3);
    load();
    check("reload A5C3", pad_cfg, 64'h0000_0000_0000_A5C3);
    w = 16'h1234;
    for (int i = 15; i >= 8; i--) shift_bit(w[i]);
    shift_rstn = 1'b0;
    tick(3);
    p0 = pulses;
    load();
    check("load in chain rst pulses", W'(pulses - p0), W'(0));
    check("load in chain rst pad_cfg", pad_cfg, 64'h0000_0000_0000_A5C3);
    shift_rstn = 1'b1;
    tick(4);
    load();
    check("chain cleared load", pad_cfg, '0);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
